demorgan_sweep_checker: RTL and testbench

//  Sequential stimulus/checker stage wrapped around the combinational De Morgan gate block.

---
 rtl/demorgan_sweep_checker.sv | 169 ++++++++++++++++
 tb/tb_demorgan_sweep_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_sweep_checker.sv
`timescale 1ns/1ps
// demorgan_sweep_checker: sweeps A/B through all four vectors into a
// De Morgan gate block and checks its six outputs against the truth table.
module demorgan_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERRW          = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            drv_A,
    output logic            drv_B,
    input  logic            nA,
    input  logic            nB,
    input  logic            nAandnB,
    input  logic            nPAorBP,
    input  logic            nAornB,
    input  logic            nPAandBP,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [3:0]      fail_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] CLAST =
        CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PLAST = PW'(PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [PW-1:0]   pidx_q, pidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drv_a_q, drv_a_d;
    logic            drv_b_q, drv_b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [3:0]      fvec_q, fvec_d;
    logic            mismatch;

    // Any of the six gate outputs disagreeing with the driven A/B.
    always_comb begin
        mismatch = 1'b0;
        if (nA !== ~drv_a_q)                   mismatch = 1'b1;
        if (nB !== ~drv_b_q)                   mismatch = 1'b1;
        if (nAandnB !== ~(drv_a_q | drv_b_q))  mismatch = 1'b1;
        if (nPAorBP !== ~(drv_a_q | drv_b_q))  mismatch = 1'b1;
        if (nAornB !== ~(drv_a_q & drv_b_q))   mismatch = 1'b1;
        if (nPAandBP !== ~(drv_a_q & drv_b_q)) mismatch = 1'b1;
    end

    // Next-state and next-output logic of the sweep FSM.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pidx_d  = pidx_q;
        cnt_d   = cnt_q;
        drv_a_d = drv_a_q;
        drv_b_d = drv_b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 2'd0;
                    pidx_d  = '0;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    fvec_d  = 4'b0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                drv_a_d = vec_q[1];
                drv_b_d = vec_q[0];
                cnt_d   = '0;
                state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CLAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != {ERRW{1'b1}}) begin
                        err_d = err_q + ERRW'(1);
                    end
                    fvec_d[vec_q] = 1'b1;
                end
                vec_d = vec_q + 2'd1;
                if (vec_q == 2'd3) begin
                    pidx_d = pidx_q + PW'(1);
                end
                if (vec_q == 2'd3 && pidx_q == PLAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            pidx_q  <= '0;
            cnt_q   <= '0;
            drv_a_q <= 1'b0;
            drv_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= 4'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
            drv_a_q <= drv_a_d;
            drv_b_q <= drv_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
        end
    end

    assign drv_A     = drv_a_q;
    assign drv_B     = drv_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
`timescale 1ns/1ps
// tb_demorgan_sweep_checker: three checker instances driving a behavioural
// gate block with selectable faults; expected results come from a scoreboard.
module tb_demorgan_sweep_checker;

    typedef struct {
        int         lat;
        int         err;
        logic [3:0] fv;
        logic       pass;
    } res_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start;
    int         f [3];
    int         sel;
    int         n_vec = 0;
    int         n_err = 0;

    res_t       res_q [$];
    logic [1:0] drv_q [$];

    wire  [2:0] d_a, d_b, busy, done, pass;
    wire  [3:0] err0, err2, fv0, fv1, fv2;
    wire  [0:0] err1;
    logic [5:0] g0, g1, g2;

    logic [3:0] obs_err, obs_fv;
    logic [1:0] obs_drv;
    logic       obs_busy, obs_done, obs_pass;

    always #5 clk = ~clk;

    // bits: nA nB nAandnB nPAorBP nAornB nPAandBP
    function automatic logic [5:0] gate(logic a, logic b, int fault);
        logic [5:0] r;
        r = {~a, ~b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
        case (fault)
            1: r[2] = 1'b0;
            2: begin
                r[3] = ~a | ~b;
                r[1] = ~a & ~b;
            end
            3: r[5] = 1'b0;
            default: ;
        endcase
        return r;
    endfunction

    assign g0 = gate(d_a[0], d_b[0], f[0]);
    assign g1 = gate(d_a[1], d_b[1], f[1]);
    assign g2 = gate(d_a[2], d_b[2], f[2]);

    demorgan_sweep_checker u0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .drv_A(d_a[0]), .drv_B(d_b[0]),
        .nA(g0[5]), .nB(g0[4]), .nAandnB(g0[3]), .nPAorBP(g0[2]),
        .nAornB(g0[1]), .nPAandBP(g0[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .fail_vec(fv0)
    );

    demorgan_sweep_checker #(.PASSES(3), .ERRW(1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .drv_A(d_a[1]), .drv_B(d_b[1]),
        .nA(g1[5]), .nB(g1[4]), .nAandnB(g1[3]), .nPAorBP(g1[2]),
        .nAornB(g1[1]), .nPAandBP(g1[0]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .fail_vec(fv1)
    );

    demorgan_sweep_checker #(.SETTLE_CYCLES(0)) u2 (
        .clk(clk), .reset(reset), .start(start[2]),
        .drv_A(d_a[2]), .drv_B(d_b[2]),
        .nA(g2[5]), .nB(g2[4]), .nAandnB(g2[3]), .nPAorBP(g2[2]),
        .nAornB(g2[1]), .nPAandBP(g2[0]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err2), .fail_vec(fv2)
    );

    always_comb begin
        obs_err = err0;
        obs_fv  = fv0;
        case (sel)
            1: begin
                obs_err = {3'b000, err1};
                obs_fv  = fv1;
            end
            2: begin
                obs_err = err2;
                obs_fv  = fv2;
            end
            default: ;
        endcase
        obs_drv  = {d_a[sel], d_b[sel]};
        obs_busy = busy[sel];
        obs_done = done[sel];
        obs_pass = pass[sel];
    end

    task automatic check_idle(input int d, input string tag);
        sel = d;
        #1;
        n_vec++;
        if ({obs_drv, obs_busy, obs_done, obs_pass, obs_err, obs_fv} !== 15'd0) begin
            n_err++;
            $display("FAIL %s dut%0d: drv=%b busy=%b done=%b pass=%b err=%0d fv=%b, want all zero",
                     tag, d, obs_drv, obs_busy, obs_done, obs_pass, obs_err, obs_fv);
        end
    endtask

    task automatic sweep(input int d, input int s, input int p, input int ew,
                         input bit poke);
        res_t       e;
        res_t       got;
        logic [1:0] vv;
        logic [1:0] ev;
        logic [5:0] g;
        logic [5:0] ideal;
        int         c;
        int         ndone;
        bit         seen;
        sel   = d;
        e.err = 0;
        e.fv  = 4'b0;
        for (int pi = 0; pi < p; pi++) begin
            for (int v = 0; v < 4; v++) begin
                vv    = 2'(v);
                g     = gate(vv[1], vv[0], f[d]);
                ideal = {~vv[1], ~vv[0], ~(vv[1] | vv[0]), ~(vv[1] | vv[0]),
                         ~(vv[1] & vv[0]), ~(vv[1] & vv[0])};
                if (g !== ideal) begin
                    if (e.err < (1 << ew) - 1) e.err++;
                    e.fv[vv] = 1'b1;
                end
                drv_q.push_back(vv);
            end
        end
        e.pass = (e.err == 0);
        e.lat  = 4 * p * (s + 2);
        res_q.push_back(e);

        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        c = 0;
        @(negedge clk);
        start[d] = 1'b0;
        ndone = 0;
        seen  = 1'b0;
        while (c <= e.lat + 6) begin
            if (c >= 1 && c <= e.lat && (c - 1) % (s + 2) == 0) begin
                ev = drv_q.pop_front();
                n_vec++;
                if (obs_drv !== ev) begin
                    n_err++;
                    $display("FAIL drv dut%0d c=%0d: got %b want %b", d, c, obs_drv, ev);
                end
            end
            if (c < e.lat) begin
                n_vec++;
                if (obs_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy dut%0d c=%0d: got %b want 1", d, c, obs_busy);
                end
            end
            if (obs_done === 1'b1) begin
                ndone++;
                if (!seen) begin
                    seen = 1'b1;
                    got  = res_q.pop_front();
                    n_vec++;
                    if (c != got.lat || obs_err !== 4'(got.err) || obs_fv !== got.fv ||
                        obs_pass !== got.pass || obs_busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL done dut%0d: c=%0d err=%0d fv=%b pass=%b busy=%b, want c=%0d err=%0d fv=%b pass=%b busy=0",
                                 d, c, obs_err, obs_fv, obs_pass, obs_busy,
                                 got.lat, got.err, got.fv, got.pass);
                    end
                end
            end
            start[d] = poke && (c == e.lat / 2 || c == e.lat);
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        start[d] = 1'b0;
        n_vec++;
        if (!seen || ndone != 1) begin
            n_err++;
            $display("FAIL done_count dut%0d: got %0d pulses want 1", d, ndone);
            if (!seen) void'(res_q.pop_front());
        end
        n_vec++;
        if (obs_drv !== 2'b11 || obs_busy !== 1'b0 || obs_err !== 4'(e.err) ||
            obs_fv !== e.fv || obs_pass !== e.pass) begin
            n_err++;
            $display("FAIL hold dut%0d: drv=%b busy=%b err=%0d fv=%b pass=%b, want 11 0 %0d %b %b",
                     d, obs_drv, obs_busy, obs_err, obs_fv, obs_pass, e.err, e.fv, e.pass);
        end
        drv_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sweep_ok();
        f[0] = 0;
        sweep(0, 2, 1, 4, 1'b0);
    endtask

    task automatic test_stuck_or();
        f[0] = 1;
        sweep(0, 2, 1, 4, 1'b0);
    endtask

    task automatic test_swap();
        f[0] = 2;
        sweep(0, 2, 1, 4, 1'b0);
    endtask

    task automatic test_multi_pass_saturate();
        f[1] = 3;
        sweep(1, 2, 3, 1, 1'b0);
    endtask

    task automatic test_no_settle_back_to_back();
        f[2] = 0;
        sweep(2, 0, 1, 4, 1'b1);
    endtask

    task automatic test_mid_reset();
        f[0] = 0;
        sel  = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (obs_drv !== 2'b01 || obs_busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: drv=%b busy=%b want 01 1", obs_drv, obs_busy);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle(0, "mid_reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "after_reset");
        sweep(0, 2, 1, 4, 1'b0);
    endtask

    initial begin
        f[0]  = 0;
        f[1]  = 0;
        f[2]  = 0;
        sel   = 0;
        reset = 1'b1;
        start = 3'b000;
        test_reset();
        test_sweep_ok();
        test_stuck_or();
        test_swap();
        test_multi_pass_saturate();
        test_no_settle_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
